// File: rtl/sequence_pkg.sv
// Shared types and constants for the serial sequence generator.
//   state_t     : generator FSM states
//   PAT_W_DEF   : default maximum pattern length in bits
//   DET_PATTERN : the pattern the downstream "1011" detector looks for
//   DET_LEN     : number of bits in DET_PATTERN
package sequence_pkg;
  localparam int         PAT_W_DEF   = 8;
  localparam logic [3:0] DET_PATTERN = 4'b1011;
  localparam int         DET_LEN     = 4;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
endpackage

// File: rtl/sequence_generator_if.sv
// Request/stream bundle between a pattern source and sequence_generator.
//   start/pattern/pat_len/repeats/abort : request side, driven by the master
//   seq_out/seq_valid/busy/done         : stream and status, driven by the slave
interface sequence_generator_if
  import sequence_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int REP_W = 4
);
  localparam int LEN_W = $clog2(PAT_W) + 1;

  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] pat_len;
  logic [REP_W-1:0] repeats;
  logic             abort;
  logic             seq_out;
  logic             seq_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, pat_len, repeats, abort,
    input  seq_out, seq_valid, busy, done
  );

  modport slave (
    input  start, pattern, pat_len, repeats, abort,
    output seq_out, seq_valid, busy, done
  );
endinterface

// File: rtl/seq_piso_shift.sv
// Pattern store plus bit-index and pass counters for sequence_generator.
//   load    : capture pattern, clamped length and repeat count
//   shift   : advance to the next bit (wrapping into the next pass)
//   nxt_bit : the bit that will be on the wire after this edge
//             (first bit of the incoming pattern while loading)
//   last    : the bit currently on the wire is the final bit of the final pass
module seq_piso_shift #(
  parameter int PAT_W = 8,
  parameter int REP_W = 4,
  localparam int LEN_W = $clog2(PAT_W) + 1,
  localparam int IDX_W = $clog2(PAT_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic [REP_W-1:0] repeats,
  output logic             nxt_bit,
  output logic             last
);
  logic [PAT_W-1:0] pat_q;
  logic [IDX_W-1:0] idx_q, top_q;
  logic [REP_W-1:0] pass_q;
  logic [LEN_W-1:0] len_c, len_m1;
  logic [IDX_W-1:0] load_idx, idx_n;

  always_comb begin
    len_c    = (pat_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : pat_len;
    len_m1   = len_c - 1'b1;
    load_idx = len_m1[IDX_W-1:0];
    // after bit 0 wrap straight back to the MSB of the used field
    idx_n    = (idx_q == '0) ? top_q : idx_q - 1'b1;
    nxt_bit  = load ? pattern[load_idx] : pat_q[idx_n];
    last     = (idx_q == '0) && (pass_q == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q  <= '0;
      idx_q  <= '0;
      top_q  <= '0;
      pass_q <= '0;
    end else if (load) begin
      pat_q  <= pattern;
      idx_q  <= load_idx;
      top_q  <= load_idx;
      pass_q <= repeats;
    end else if (shift) begin
      idx_q <= idx_n;
      if (idx_q == '0) pass_q <= pass_q - 1'b1;
    end
  end
endmodule

// File: rtl/sequence_generator.sv
// Serial pattern generator: sends pat_len bits of pattern MSB-first,
// repeats+1 times back to back, then pulses done for one cycle.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : request inputs and registered stream/status outputs
module sequence_generator
  import sequence_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int REP_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  sequence_generator_if.slave  bus
);
  state_t state_q, state_n;
  logic   load, shift, nxt_bit, last, accept;
  logic   seq_out_d, seq_valid_d, busy_d, done_d;
  logic   seq_out_q, seq_valid_q, busy_q, done_q;

  assign accept = bus.start && !bus.abort && (bus.pat_len != '0);

  seq_piso_shift #(.PAT_W(PAT_W), .REP_W(REP_W)) u_shift (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .shift   (shift),
    .pattern (bus.pattern),
    .pat_len (bus.pat_len),
    .repeats (bus.repeats),
    .nxt_bit (nxt_bit),
    .last    (last)
  );

  // Outputs are computed for the state being entered so that every
  // output is a flop and the first bit shows one cycle after start.
  always_comb begin
    state_n     = state_q;
    load        = 1'b0;
    shift       = 1'b0;
    seq_out_d   = 1'b0;
    seq_valid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: if (accept) begin
        load        = 1'b1;
        state_n     = SEND;
        seq_out_d   = nxt_bit;
        seq_valid_d = 1'b1;
        busy_d      = 1'b1;
      end
      SEND: begin
        if (bus.abort) begin
          state_n = IDLE;
        end else if (last) begin
          state_n = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b1;
        end else begin
          shift       = 1'b1;
          seq_out_d   = nxt_bit;
          seq_valid_d = 1'b1;
          busy_d      = 1'b1;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      seq_out_q   <= 1'b0;
      seq_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      seq_out_q   <= seq_out_d;
      seq_valid_q <= seq_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.seq_out   = seq_out_q;
  assign bus.seq_valid = seq_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator with a Moore "1011" detector
// watching the serial stream.
module tb_sequence_generator;
  import sequence_pkg::*;

  localparam int PAT_W = 8;
  localparam int REP_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vec = 0;
  int   errs = 0;

  sequence_generator_if #(.PAT_W(PAT_W), .REP_W(REP_W)) bus ();

  sequence_generator #(.PAT_W(PAT_W), .REP_W(REP_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Moore detector: output is a function of the last four valid bits only.
  logic [3:0] det_sh;
  int         det_nb;
  logic       det_out;
  logic       det_prev = 1'b0;
  int         det_cnt = 0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      det_sh <= '0;
      det_nb <= 0;
    end else if (bus.seq_valid) begin
      det_sh <= {det_sh[2:0], bus.seq_out};
      if (det_nb < DET_LEN) det_nb <= det_nb + 1;
    end
  end
  assign det_out = (det_sh == DET_PATTERN) && (det_nb >= DET_LEN);

  always @(negedge clk) begin
    if (det_out && !det_prev) det_cnt++;
    det_prev = det_out;
  end

  logic so_r [32];
  logic sv_r [32];
  logic dn_r [32];
  logic by_r [32];

  // record outputs on n consecutive negedges, starting with the current one
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      so_r[i] = bus.seq_out;
      sv_r[i] = bus.seq_valid;
      dn_r[i] = bus.done;
      by_r[i] = bus.busy;
    end
  endtask

  // fold the captured valid bits into a word, first bit ends up as MSB
  task automatic collect(input int n, output logic [15:0] s, output int nv, output int nd);
    s = '0; nv = 0; nd = 0;
    for (int i = 0; i < n; i++) begin
      if (sv_r[i]) begin
        s = {s[14:0], so_r[i]};
        nv++;
      end
      if (dn_r[i]) nd++;
    end
  endtask

  // called at a negedge; leaves us at the negedge of the first output cycle
  task automatic kick(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
    bus.pattern = p;
    bus.pat_len = l;
    bus.repeats = r;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.pattern = '0; bus.pat_len = '0; bus.repeats = '0;
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    vec++; if (bus.seq_out !== 1'b0)   begin errs++; $display("FAIL reset_seq_out got %b want 0", bus.seq_out); end
    vec++; if (bus.seq_valid !== 1'b0) begin errs++; $display("FAIL reset_seq_valid got %b want 0", bus.seq_valid); end
    vec++; if (bus.busy !== 1'b0)      begin errs++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    vec++; if (bus.done !== 1'b0)      begin errs++; $display("FAIL reset_done got %b want 0", bus.done); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [3:0] exp_b;
    exp_b = 4'b1011;
    kick(8'h0B, 4'd4, 4'd0);
    capture(6);
    for (int i = 0; i < 4; i++) begin
      vec++; if (so_r[i] !== exp_b[3-i]) begin errs++; $display("FAIL basic_bit%0d got %b want %b", i, so_r[i], exp_b[3-i]); end
      vec++; if (sv_r[i] !== 1'b1) begin errs++; $display("FAIL basic_valid%0d got %b want 1", i, sv_r[i]); end
    end
    vec++; if (by_r[0] !== 1'b1) begin errs++; $display("FAIL basic_busy0 got %b want 1", by_r[0]); end
    vec++; if (dn_r[4] !== 1'b1) begin errs++; $display("FAIL basic_done5 got %b want 1", dn_r[4]); end
    vec++; if (sv_r[4] !== 1'b0 || so_r[4] !== 1'b0) begin errs++; $display("FAIL basic_done_quiet got v=%b o=%b want 0/0", sv_r[4], so_r[4]); end
    vec++; if (by_r[4] !== 1'b1) begin errs++; $display("FAIL basic_busy_done got %b want 1", by_r[4]); end
    vec++; if (by_r[5] !== 1'b0 || dn_r[5] !== 1'b0) begin errs++; $display("FAIL basic_idle got busy=%b done=%b want 0/0", by_r[5], dn_r[5]); end
  endtask

  task automatic test_repeat();
    logic [15:0] s; int nv, nd, d0;
    d0 = det_cnt;
    kick(8'h0B, 4'd4, 4'd1);
    capture(10);
    collect(10, s, nv, nd);
    @(negedge clk);
    vec++; if (nv != 8) begin errs++; $display("FAIL repeat_count got %0d want 8", nv); end
    vec++; if (s[7:0] !== 8'hBB) begin errs++; $display("FAIL repeat_stream got %b want 10111011", s[7:0]); end
    vec++; if (dn_r[8] !== 1'b1 || nd != 1) begin errs++; $display("FAIL repeat_done got c8=%b n=%0d want 1/1", dn_r[8], nd); end
    vec++; if (det_cnt - d0 != 2) begin errs++; $display("FAIL repeat_detect got %0d want 2", det_cnt - d0); end
  endtask

  task automatic test_abort();
    int nd;
    kick(8'hA5, 4'd8, 4'd0);
    vec++; if (bus.seq_out !== 1'b1 || bus.seq_valid !== 1'b1) begin errs++; $display("FAIL abort_bit0 got o=%b v=%b want 1/1", bus.seq_out, bus.seq_valid); end
    // start while busy, with a different pattern on the inputs
    bus.start = 1'b1; bus.pattern = 8'h00;
    @(negedge clk);
    vec++; if (bus.seq_out !== 1'b0 || bus.seq_valid !== 1'b1) begin errs++; $display("FAIL abort_bit1 got o=%b v=%b want 0/1", bus.seq_out, bus.seq_valid); end
    @(negedge clk);
    vec++; if (bus.seq_out !== 1'b1 || bus.seq_valid !== 1'b1) begin errs++; $display("FAIL abort_bit2 got o=%b v=%b want 1/1", bus.seq_out, bus.seq_valid); end
    bus.abort = 1'b1;
    @(negedge clk);
    vec++; if (bus.seq_valid !== 1'b0 || bus.seq_out !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0)
      begin errs++; $display("FAIL abort_stop got v=%b o=%b b=%b d=%b want 0000", bus.seq_valid, bus.seq_out, bus.busy, bus.done); end
    bus.abort = 1'b0; bus.start = 1'b0;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done || bus.seq_valid || bus.busy) nd++;
    end
    vec++; if (nd != 0) begin errs++; $display("FAIL abort_quiet got %0d active cycles want 0", nd); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ev, eo, ed;
    ev = 6'b110011; eo = 6'b100010; ed = 6'b001000;
    bus.pattern = 8'h02; bus.pat_len = 4'd2; bus.repeats = 4'd0; bus.start = 1'b1;
    @(negedge clk);
    capture(6);
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      vec++;
      if (sv_r[i] !== ev[5-i] || so_r[i] !== eo[5-i] || dn_r[i] !== ed[5-i]) begin
        errs++; $display("FAIL b2b_c%0d got v=%b o=%b d=%b want %b/%b/%b", i, sv_r[i], so_r[i], dn_r[i], ev[5-i], eo[5-i], ed[5-i]);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_len_edges();
    logic [15:0] s; int nv, nd, act;
    kick(8'hFF, 4'd0, 4'd0);
    capture(5);
    act = 0;
    for (int i = 0; i < 5; i++) if (sv_r[i] || dn_r[i] || by_r[i]) act++;
    vec++; if (act != 0) begin errs++; $display("FAIL len0_quiet got %0d active cycles want 0", act); end
    kick(8'hCA, 4'd9, 4'd0);
    capture(10);
    collect(10, s, nv, nd);
    vec++; if (nv != 8) begin errs++; $display("FAIL len9_count got %0d want 8", nv); end
    vec++; if (s[7:0] !== 8'hCA) begin errs++; $display("FAIL len9_stream got %h want ca", s[7:0]); end
    vec++; if (dn_r[8] !== 1'b1) begin errs++; $display("FAIL len9_done got %b want 1", dn_r[8]); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [15:0] s; int nv, nd;
    kick(8'hA5, 4'd8, 4'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    vec++; if (bus.seq_valid !== 1'b0 || bus.seq_out !== 1'b0 || bus.busy !== 1'b0)
      begin errs++; $display("FAIL rstmid_async got v=%b o=%b b=%b want 000", bus.seq_valid, bus.seq_out, bus.busy); end
    @(negedge clk);
    vec++; if (bus.seq_valid !== 1'b0 || bus.busy !== 1'b0) begin errs++; $display("FAIL rstmid_hold got v=%b b=%b want 00", bus.seq_valid, bus.busy); end
    reset = 1'b0;
    kick(8'hA5, 4'd8, 4'd0);
    capture(10);
    collect(10, s, nv, nd);
    vec++; if (nv != 8 || s[7:0] !== 8'hA5) begin errs++; $display("FAIL rstmid_restart got n=%0d s=%h want 8/a5", nv, s[7:0]); end
    vec++; if (dn_r[8] !== 1'b1 || nd != 1) begin errs++; $display("FAIL rstmid_done got c8=%b n=%0d want 1/1", dn_r[8], nd); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_repeat();
    test_abort();
    test_back_to_back();
    test_len_edges();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
